half_adder: RTL and testbench



---
 rtl/half_adder_if.sv | 29 ++
 rtl/half_adder.sv | 84 ++++++++
 tb/tb_half_adder.sv | 154 +++++++++++++++
 3 files changed

// File: rtl/half_adder_if.sv
// Tiny Tapeout user-tile pin bundle shared by the half_adder tile and its driver.
interface half_adder_if;
  logic       ena;
  logic [7:0] ui_in;
  logic [7:0] uo_out;
  logic [7:0] uio_in;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  // Driver side (TT wrapper / testbench)
  modport master (
    output ena,
    output ui_in,
    output uio_in,
    input  uo_out,
    input  uio_out,
    input  uio_oe
  );

  // Tile side
  modport slave (
    input  ena,
    input  ui_in,
    input  uio_in,
    output uo_out,
    output uio_out,
    output uio_oe
  );
endinterface

// File: rtl/half_adder.sv
// half_adder: Tiny Tapeout tile with a 1-bit half adder on ui_in[1:0].
// uo_out = {carry_cnt[3:0], carry_q, sum_q, carry, sum}.
// Optional macro HA_UIO_DEBUG_EN drives an 8-bit sum-event counter on uio_out.
module half_adder (
  input  logic         clk,
  input  logic         rst_n,
  half_adder_if.slave  tt
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DBG_W = 8;

  logic             w_a;
  logic             w_b;
  logic             w_clr;
  logic             w_sum;
  logic             w_carry;
  logic             w_unused;

  logic             r_sum_q;
  logic             r_carry_q;
  logic [CNT_W-1:0] r_carry_cnt;

  assign w_a     = tt.ui_in[0];
  assign w_b     = tt.ui_in[1];
  assign w_clr   = tt.ui_in[2];

  // Zero-latency adder; live even while reset is asserted
  assign w_sum   = w_a ^ w_b;
  assign w_carry = w_a & w_b;

  // Spare inputs are deliberately ignored
  assign w_unused = &{1'b0, tt.ui_in[7:3], tt.uio_in};

  // Registered copies of sum/carry, held while the tile is not selected
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum_q   <= 1'b0;
      r_carry_q <= 1'b0;
    end else if (tt.ena) begin
      r_sum_q   <= w_sum;
      r_carry_q <= w_carry;
    end
  end

  // Wrapping carry-event counter; clear wins over increment
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_cnt <= '0;
    end else if (tt.ena) begin
      if (w_clr) begin
        r_carry_cnt <= '0;
      end else if (w_carry) begin
        r_carry_cnt <= r_carry_cnt + CNT_W'(1);
      end
    end
  end

  assign tt.uo_out = {r_carry_cnt, r_carry_q, r_sum_q, w_carry, w_sum};

`ifdef HA_UIO_DEBUG_EN
  logic [DBG_W-1:0] r_dbg_cnt;

  // Wrapping sum-event counter for bring-up visibility on the bidir pins
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dbg_cnt <= '0;
    end else if (tt.ena) begin
      if (w_clr) begin
        r_dbg_cnt <= '0;
      end else if (w_sum) begin
        r_dbg_cnt <= r_dbg_cnt + DBG_W'(1);
      end
    end
  end

  assign tt.uio_out = r_dbg_cnt;
  assign tt.uio_oe  = 8'hFF;
`else
  assign tt.uio_out = 8'h00;
  assign tt.uio_oe  = 8'h00;
`endif

endmodule

// File: tb/tb_half_adder.sv
// Directed self-checking bench for the half_adder tile (both macro builds).
module tb_half_adder;

`ifdef HA_UIO_DEBUG_EN
  localparam bit DBG_ON = 1'b1;
`else
  localparam bit DBG_ON = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  half_adder_if tt ();

  half_adder u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .tt    (tt.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge
  task automatic tick(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_uio(input string tag, input logic [7:0] dbg_exp);
    chk({tag, "_uio_out"}, tt.uio_out, DBG_ON ? dbg_exp : 8'h00);
    chk({tag, "_uio_oe"},  tt.uio_oe,  DBG_ON ? 8'hFF : 8'h00);
  endtask

  logic [1:0] exp_sc [4];

  initial begin
    n_checks = 0;
    n_errors = 0;
    exp_sc[0] = 2'b00;
    exp_sc[1] = 2'b01;
    exp_sc[2] = 2'b01;
    exp_sc[3] = 2'b10;

    // Reset state; combinational path live during reset
    rst_n     = 1'b0;
    tt.ena    = 1'b0;
    tt.ui_in  = 8'h00;
    tt.uio_in = 8'hA5;
    #3;
    chk("rst_uo_out", tt.uo_out, 8'h00);
    chk_uio("rst", 8'h00);
    tt.ui_in = 8'h03;
    #1;
    chk("rst_comb_live", tt.uo_out, 8'h02);
    tt.ui_in = 8'h00;
    #8;
    rst_n = 1'b1;
    tick(1);

    // 1: truth table, registered copy one edge later; noise on ui_in[7:3]
    tt.ena = 1'b1;
    for (int v = 0; v < 4; v++) begin
      tt.ui_in = {5'b10101, 1'b0, 2'(v)};
      #1;
      chk($sformatf("comb_v%0d", v), {6'b0, tt.uo_out[1:0]}, {6'b0, exp_sc[v]});
      tick(1);
      chk($sformatf("reg_v%0d", v), {6'b0, tt.uo_out[3:2]}, {6'b0, exp_sc[v]});
    end
    chk("t1_cnt", {4'h0, tt.uo_out[7:4]}, 8'h01);
    chk_uio("t1", 8'h02);

    // Clear both counters
    tt.ui_in = 8'h04;
    tick(1);
    chk("clr_cnt", {4'h0, tt.uo_out[7:4]}, 8'h00);

    // 2: wrap check over 17 carry edges
    tt.ui_in = 8'h03;
    for (int i = 0; i < 17; i++) begin
      tick(1);
      chk($sformatf("wrap_%0d", i), {4'h0, tt.uo_out[7:4]}, {4'h0, 4'(i + 1)});
    end
    chk("t2_uo_out", tt.uo_out, 8'h1A);

    // 3: clr has priority over carry
    tick(4);
    chk("t3_cnt5", {4'h0, tt.uo_out[7:4]}, 8'h05);
    tt.ui_in = 8'h07;
    tick(1);
    chk("t3_clr_prio", tt.uo_out, 8'h0A);

    // 4: ena=0 holds everything, clr included
    tt.ui_in = 8'h03;
    tick(2);
    tt.ui_in = 8'h01;
    tick(1);
    chk("t4_pre", tt.uo_out, 8'h25);
    tt.ena   = 1'b0;
    tt.ui_in = 8'h03;
    tick(10);
    chk("t4_hold", tt.uo_out, 8'h26);
    tt.ui_in = 8'h07;
    tick(1);
    chk("t4_hold_clr", tt.uo_out, 8'h26);
    chk_uio("t4", 8'h01);

    // 5: count to 9, then async reset between edges
    tt.ena   = 1'b1;
    tt.ui_in = 8'h03;
    tick(7);
    chk("t5_cnt9", tt.uo_out, 8'h9A);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t5_async_rst", tt.uo_out, 8'h02);
    chk_uio("t5_rst", 8'h00);
    tt.ui_in = 8'h01;
    #1;
    chk("t5_comb_in_rst", tt.uo_out, 8'h01);
    tick(1);
    chk("t5_edge_in_rst", tt.uo_out, 8'h01);
    tt.ui_in = 8'h03;
    #3;
    rst_n = 1'b1;
    tick(1);
    chk("t5_first_inc", tt.uo_out, 8'h1A);

    // 6: debug sum-event counter
    tt.ui_in = 8'h04;
    tick(1);
    chk_uio("t6_clr", 8'h00);
    tt.ui_in = 8'h01;
    tick(3);
    chk_uio("t6", 8'h03);
    chk("t6_uo_out", tt.uo_out, 8'h05);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
